// File: rtl/alu_rs.sv
// alu_rs: reservation station for non-memory instructions (ALU, branch, JAL/JALR, LUI/AUIPC).
// Latency: an entry written with both operands ready at edge E issues at edge E+1 (ALUEn_o high E+1..E+2).
// Backpressure: RSFull_o (combinational, AND of valid bits) stalls dispatch; the ALU never stalls issue.
// Ports: clk/rst (sync, active-high), rdy (global freeze), clr_i (flush),
//        RS* dispatch write, cdb1*/cdb2* result broadcast snoop, ALU* registered issue outputs.
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr_i,
  input  logic              RSEn_i,
  input  logic [OP_W-1:0]   RSOpcode_i,
  input  logic [DATA_W-1:0] RSPc_i,
  input  logic [DATA_W-1:0] RSImm_i,
  input  logic [DATA_W-1:0] RSr1Data_i,
  input  logic [DATA_W-1:0] RSr2Data_i,
  input  logic [ROB_W-1:0]  RSr1Id_i,
  input  logic [ROB_W-1:0]  RSr2Id_i,
  input  logic [ROB_W-1:0]  RSId_i,
  output logic              RSFull_o,
  input  logic              cdb1En_i,
  input  logic [ROB_W-1:0]  cdb1Id_i,
  input  logic [DATA_W-1:0] cdb1Data_i,
  input  logic              cdb2En_i,
  input  logic [ROB_W-1:0]  cdb2Id_i,
  input  logic [DATA_W-1:0] cdb2Data_i,
  output logic              ALUEn_o,
  output logic [OP_W-1:0]   ALUOpcode_o,
  output logic [DATA_W-1:0] ALUPc_o,
  output logic [DATA_W-1:0] ALUImm_o,
  output logic [DATA_W-1:0] ALUr1Data_o,
  output logic [DATA_W-1:0] ALUr2Data_o,
  output logic [ROB_W-1:0]  ALUId_o
);

  // Entry storage. Only valid is reset; payload is don't-care while invalid.
  logic [DEPTH-1:0]  valid_q;
  logic [OP_W-1:0]   op_q  [DEPTH];
  logic [DATA_W-1:0] pc_q  [DEPTH];
  logic [DATA_W-1:0] imm_q [DEPTH];
  logic [DATA_W-1:0] vj_q  [DEPTH];
  logic [DATA_W-1:0] vk_q  [DEPTH];
  logic [ROB_W-1:0]  qj_q  [DEPTH];
  logic [ROB_W-1:0]  qk_q  [DEPTH];
  logic [ROB_W-1:0]  id_q  [DEPTH];

  // Resolve one operand against both CDB ports. Tag 0 means "already have
  // the value" and must never match; cdb1 takes precedence over cdb2.
  function automatic logic [ROB_W+DATA_W-1:0] snoop(
    input logic [ROB_W-1:0]  tag,
    input logic [DATA_W-1:0] data,
    input logic              c1_en,
    input logic [ROB_W-1:0]  c1_id,
    input logic [DATA_W-1:0] c1_data,
    input logic              c2_en,
    input logic [ROB_W-1:0]  c2_id,
    input logic [DATA_W-1:0] c2_data
  );
    logic [ROB_W+DATA_W-1:0] res;
    res = {tag, data};
    if (tag != '0) begin
      if (c1_en && (c1_id == tag))      res = {{ROB_W{1'b0}}, c1_data};
      else if (c2_en && (c2_id == tag)) res = {{ROB_W{1'b0}}, c2_data};
    end
    return res;
  endfunction

  logic [ROB_W-1:0]  snp_qj [DEPTH];
  logic [ROB_W-1:0]  snp_qk [DEPTH];
  logic [DATA_W-1:0] snp_vj [DEPTH];
  logic [DATA_W-1:0] snp_vk [DEPTH];
  logic [ROB_W-1:0]  wr_qj, wr_qk;
  logic [DATA_W-1:0] wr_vj, wr_vk;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {snp_qj[i], snp_vj[i]} = snoop(qj_q[i], vj_q[i], cdb1En_i, cdb1Id_i, cdb1Data_i,
                                     cdb2En_i, cdb2Id_i, cdb2Data_i);
      {snp_qk[i], snp_vk[i]} = snoop(qk_q[i], vk_q[i], cdb1En_i, cdb1Id_i, cdb1Data_i,
                                     cdb2En_i, cdb2Id_i, cdb2Data_i);
    end
    // A producer may broadcast in the very cycle its consumer is dispatched.
    {wr_qj, wr_vj} = snoop(RSr1Id_i, RSr1Data_i, cdb1En_i, cdb1Id_i, cdb1Data_i,
                           cdb2En_i, cdb2Id_i, cdb2Data_i);
    {wr_qk, wr_vk} = snoop(RSr2Id_i, RSr2Data_i, cdb1En_i, cdb1Id_i, cdb1Data_i,
                           cdb2En_i, cdb2Id_i, cdb2Data_i);
  end

  // Readiness uses registered tags only, so a snoop capture costs one edge
  // before the entry can issue.
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] free_idx, iss_idx;
  logic             have_free, have_iss;

  always_comb begin
    ready     = '0;
    free_idx  = '0;
    iss_idx   = '0;
    have_free = 1'b0;
    have_iss  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
    // Walk downwards so the lowest index ends up selected.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx  = IDX_W'(i);
        have_free = 1'b1;
      end
      if (ready[i]) begin
        iss_idx  = IDX_W'(i);
        have_iss = 1'b1;
      end
    end
  end

  // Full is computed from pre-edge valid bits: a slot being issued this
  // cycle is not yet free, and the write never targets the issuing slot.
  assign RSFull_o = &valid_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      valid_q     <= '0;
      ALUEn_o     <= 1'b0;
      ALUOpcode_o <= '0;
      ALUPc_o     <= '0;
      ALUImm_o    <= '0;
      ALUr1Data_o <= '0;
      ALUr2Data_o <= '0;
      ALUId_o     <= '0;
    end else if (rdy) begin
      ALUEn_o <= have_iss;
      if (have_iss) begin
        ALUOpcode_o       <= op_q[iss_idx];
        ALUPc_o           <= pc_q[iss_idx];
        ALUImm_o          <= imm_q[iss_idx];
        ALUr1Data_o       <= vj_q[iss_idx];
        ALUr2Data_o       <= vk_q[iss_idx];
        ALUId_o           <= id_q[iss_idx];
        valid_q[iss_idx]  <= 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i]) begin
          qj_q[i] <= snp_qj[i];
          vj_q[i] <= snp_vj[i];
          qk_q[i] <= snp_qk[i];
          vk_q[i] <= snp_vk[i];
        end
      end
      if (RSEn_i && have_free) begin
        valid_q[free_idx] <= 1'b1;
        op_q[free_idx]    <= RSOpcode_i;
        pc_q[free_idx]    <= RSPc_i;
        imm_q[free_idx]   <= RSImm_i;
        id_q[free_idx]    <= RSId_i;
        qj_q[free_idx]    <= wr_qj;
        vj_q[free_idx]    <= wr_vj;
        qk_q[free_idx]    <= wr_qk;
        vk_q[free_idx]    <= wr_vk;
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: self-checking bench for alu_rs.
// Table of single-dispatch vectors, hand sequences for fill/order/flush/freeze,
// then randomized traffic against a behavioural model of the station.
module tb_alu_rs;
  localparam int DEPTH = 8, IDX_W = 3, ROB_W = 4, OP_W = 6, DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1, rdy = 1'b1, clr_i = 1'b0;
  logic RSEn_i = 1'b0;
  logic [OP_W-1:0]   RSOpcode_i = '0;
  logic [DATA_W-1:0] RSPc_i = '0, RSImm_i = '0, RSr1Data_i = '0, RSr2Data_i = '0;
  logic [ROB_W-1:0]  RSr1Id_i = '0, RSr2Id_i = '0, RSId_i = '0;
  logic              RSFull_o;
  logic              cdb1En_i = 1'b0, cdb2En_i = 1'b0;
  logic [ROB_W-1:0]  cdb1Id_i = '0, cdb2Id_i = '0;
  logic [DATA_W-1:0] cdb1Data_i = '0, cdb2Data_i = '0;
  logic              ALUEn_o;
  logic [OP_W-1:0]   ALUOpcode_o;
  logic [DATA_W-1:0] ALUPc_o, ALUImm_o, ALUr1Data_o, ALUr2Data_o;
  logic [ROB_W-1:0]  ALUId_o;

  alu_rs #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ROB_W(ROB_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr_i(clr_i),
    .RSEn_i(RSEn_i), .RSOpcode_i(RSOpcode_i), .RSPc_i(RSPc_i), .RSImm_i(RSImm_i),
    .RSr1Data_i(RSr1Data_i), .RSr2Data_i(RSr2Data_i), .RSr1Id_i(RSr1Id_i),
    .RSr2Id_i(RSr2Id_i), .RSId_i(RSId_i), .RSFull_o(RSFull_o),
    .cdb1En_i(cdb1En_i), .cdb1Id_i(cdb1Id_i), .cdb1Data_i(cdb1Data_i),
    .cdb2En_i(cdb2En_i), .cdb2Id_i(cdb2Id_i), .cdb2Data_i(cdb2Data_i),
    .ALUEn_o(ALUEn_o), .ALUOpcode_o(ALUOpcode_o), .ALUPc_o(ALUPc_o), .ALUImm_o(ALUImm_o),
    .ALUr1Data_o(ALUr1Data_o), .ALUr2Data_o(ALUr2Data_o), .ALUId_o(ALUId_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic              v;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] pc, imm, vj, vk;
    logic [ROB_W-1:0]  qj, qk, id;
  } ent_t;

  ent_t m [DEPTH];
  logic              m_en = 1'b0;
  logic [OP_W-1:0]   m_op = '0;
  logic [DATA_W-1:0] m_pc = '0, m_imm = '0, m_r1 = '0, m_r2 = '0;
  logic [ROB_W-1:0]  m_id = '0;

  // Operand waiting on tag q picks up a broadcast value; cdb1 first, tag 0 never waits.
  function automatic logic [ROB_W+DATA_W-1:0] res(input logic [ROB_W-1:0] q, input logic [DATA_W-1:0] d);
    if (q == 0) return {q, d};
    if (cdb1En_i && cdb1Id_i == q) return {{ROB_W{1'b0}}, cdb1Data_i};
    if (cdb2En_i && cdb2Id_i == q) return {{ROB_W{1'b0}}, cdb2Data_i};
    return {q, d};
  endfunction

  function automatic logic m_full();
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    ent_t nxt [DEPTH];
    int pick, slot;
    nxt = m;
    if (rst || clr_i) begin
      for (int i = 0; i < DEPTH; i++) nxt[i].v = 1'b0;
      m_en = 1'b0; m_op = '0; m_pc = '0; m_imm = '0; m_r1 = '0; m_r2 = '0; m_id = '0;
    end else if (rdy) begin
      pick = -1;
      for (int i = 0; i < DEPTH; i++)
        if (pick < 0 && m[i].v && m[i].qj == 0 && m[i].qk == 0) pick = i;
      m_en = (pick >= 0);
      if (pick >= 0) begin
        m_op = m[pick].op; m_pc = m[pick].pc; m_imm = m[pick].imm;
        m_r1 = m[pick].vj; m_r2 = m[pick].vk; m_id = m[pick].id;
        nxt[pick].v = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) if (m[i].v) begin
        {nxt[i].qj, nxt[i].vj} = res(m[i].qj, m[i].vj);
        {nxt[i].qk, nxt[i].vk} = res(m[i].qk, m[i].vk);
      end
      slot = -1;
      for (int i = 0; i < DEPTH; i++) if (slot < 0 && !m[i].v) slot = i;
      if (RSEn_i && slot >= 0) begin
        nxt[slot].v = 1'b1; nxt[slot].op = RSOpcode_i; nxt[slot].pc = RSPc_i;
        nxt[slot].imm = RSImm_i; nxt[slot].id = RSId_i;
        {nxt[slot].qj, nxt[slot].vj} = res(RSr1Id_i, RSr1Data_i);
        {nxt[slot].qk, nxt[slot].vk} = res(RSr2Id_i, RSr2Data_i);
      end
    end
    m = nxt;
  endtask

  // Model follows every edge; inputs are set between edges.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RSEn_i = 1'b0; cdb1En_i = 1'b0; cdb2En_i = 1'b0; clr_i = 1'b0; rdy = 1'b1; rst = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic dispatch(input logic [ROB_W-1:0] r1id, input logic [ROB_W-1:0] r2id,
                          input logic [DATA_W-1:0] r1, input logic [DATA_W-1:0] r2,
                          input logic [ROB_W-1:0] id);
    RSEn_i = 1'b1; RSr1Id_i = r1id; RSr2Id_i = r2id; RSr1Data_i = r1; RSr2Data_i = r2;
    RSId_i = id; RSOpcode_i = 6'(id) ^ 6'h15; RSPc_i = 32'h4000 + 32'(id) * 4;
    RSImm_i = 32'h100 + 32'(id);
  endtask

  task automatic cdb1(input logic [ROB_W-1:0] id, input logic [DATA_W-1:0] d);
    cdb1En_i = 1'b1; cdb1Id_i = id; cdb1Data_i = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [ROB_W-1:0]  r1id, r2id;
    logic [DATA_W-1:0] r1, r2;
    logic              c1en;
    logic [ROB_W-1:0]  c1id;
    logic [DATA_W-1:0] c1d;
    logic              c2en;
    logic [ROB_W-1:0]  c2id;
    logic [DATA_W-1:0] c2d;
    logic              iss;
    logic [DATA_W-1:0] er1, er2;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    vecs[0] = '{r1id:0, r2id:0, r1:5, r2:7, c1en:0, c1id:0, c1d:0, c2en:0, c2id:0, c2d:0, iss:1, er1:5, er2:7};
    vecs[1] = '{r1id:4, r2id:5, r1:32'hdead, r2:32'hbeef, c1en:1, c1id:4, c1d:32'hA, c2en:1, c2id:5, c2d:32'hB, iss:1, er1:32'hA, er2:32'hB};
    vecs[2] = '{r1id:4, r2id:4, r1:0, r2:0, c1en:1, c1id:4, c1d:32'hA, c2en:1, c2id:4, c2d:32'hB, iss:1, er1:32'hA, er2:32'hA};
    vecs[3] = '{r1id:3, r2id:0, r1:0, r2:2, c1en:0, c1id:3, c1d:32'h30, c2en:0, c2id:3, c2d:32'h31, iss:0, er1:0, er2:0};
    vecs[4] = '{r1id:0, r2id:0, r1:9, r2:8, c1en:1, c1id:0, c1d:32'hFF, c2en:1, c2id:0, c2d:32'hEE, iss:1, er1:9, er2:8};
    vecs[5] = '{r1id:0, r2id:7, r1:1, r2:0, c1en:0, c1id:0, c1d:0, c2en:1, c2id:7, c2d:32'h77, iss:1, er1:1, er2:32'h77};
    vecs[6] = '{r1id:2, r2id:3, r1:0, r2:0, c1en:1, c1id:3, c1d:32'h33, c2en:1, c2id:2, c2d:32'h22, iss:1, er1:32'h22, er2:32'h33};

    do_reset();
    chk("reset_en", 64'(ALUEn_o), 64'(0));
    chk("reset_full", 64'(RSFull_o), 64'(0));
    chk("reset_id", 64'(ALUId_o), 64'(0));
    chk("reset_r1", 64'(ALUr1Data_o), 64'(0));

    // Single dispatch per row, optional same-cycle broadcast.
    for (int k = 0; k < NV; k++) begin
      do_reset();
      dispatch(vecs[k].r1id, vecs[k].r2id, vecs[k].r1, vecs[k].r2, 4'(k + 3));
      cdb1En_i = vecs[k].c1en; cdb1Id_i = vecs[k].c1id; cdb1Data_i = vecs[k].c1d;
      cdb2En_i = vecs[k].c2en; cdb2Id_i = vecs[k].c2id; cdb2Data_i = vecs[k].c2d;
      tick();
      idle();
      chk("vec_full", 64'(RSFull_o), 64'(0));
      tick();
      chk("vec_en", 64'(ALUEn_o), 64'(vecs[k].iss));
      if (vecs[k].iss) begin
        chk("vec_r1", 64'(ALUr1Data_o), 64'(vecs[k].er1));
        chk("vec_r2", 64'(ALUr2Data_o), 64'(vecs[k].er2));
        chk("vec_id", 64'(ALUId_o), 64'(k + 3));
        chk("vec_op", 64'(ALUOpcode_o), 64'(6'(k + 3) ^ 6'h15));
        chk("vec_pc", 64'(ALUPc_o), 64'(32'h4000 + 32'(k + 3) * 4));
        chk("vec_imm", 64'(ALUImm_o), 64'(32'h100 + 32'(k + 3)));
      end
      tick();
      chk("vec_pulse", 64'(ALUEn_o), 64'(0));
    end

    // Operand arrives later via CDB; capture edge, then issue edge.
    do_reset();
    dispatch(2, 0, 0, 1, 9);
    tick(); idle();
    tick(); chk("wait_en0", 64'(ALUEn_o), 64'(0));
    tick(); chk("wait_en1", 64'(ALUEn_o), 64'(0));
    cdb1(2, 32'h10);
    tick(); idle();
    chk("wait_capture_edge", 64'(ALUEn_o), 64'(0));
    tick();
    chk("wait_en", 64'(ALUEn_o), 64'(1));
    chk("wait_r1", 64'(ALUr1Data_o), 64'(32'h10));
    chk("wait_r2", 64'(ALUr2Data_o), 64'(1));
    chk("wait_id", 64'(ALUId_o), 64'(9));

    // Fill all slots waiting on tag 6, overflow write ignored, in-order drain.
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      dispatch(6, 0, 0, 32'(k), 4'(8 + k));
      tick();
    end
    idle();
    chk("fill_full", 64'(RSFull_o), 64'(1));
    dispatch(0, 0, 32'h5, 32'h6, 1);
    tick(); idle();
    chk("fill_full_after_extra", 64'(RSFull_o), 64'(1));
    cdb1(6, 32'h66);
    tick(); idle();
    chk("fill_capture_en", 64'(ALUEn_o), 64'(0));
    chk("fill_capture_full", 64'(RSFull_o), 64'(1));
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      chk("drain_en", 64'(ALUEn_o), 64'(1));
      chk("drain_id", 64'(ALUId_o), 64'(8 + k));
      chk("drain_r1", 64'(ALUr1Data_o), 64'(32'h66));
      chk("drain_r2", 64'(ALUr2Data_o), 64'(k));
      if (k == 0) chk("drain_full", 64'(RSFull_o), 64'(0));
    end
    tick();
    chk("drain_done", 64'(ALUEn_o), 64'(0));

    // Slots 1 and 4 become ready together while 0, 2, 3 keep waiting.
    do_reset();
    dispatch(9, 0, 0, 0, 1);  tick();
    dispatch(10, 0, 0, 0, 2); tick();
    dispatch(9, 0, 0, 0, 3);  tick();
    dispatch(9, 0, 0, 0, 4);  tick();
    dispatch(10, 0, 0, 0, 5); tick();
    idle(); cdb1(10, 32'hAB);
    tick(); idle();
    tick();
    chk("order_en_a", 64'(ALUEn_o), 64'(1));
    chk("order_id_a", 64'(ALUId_o), 64'(2));
    chk("order_r1_a", 64'(ALUr1Data_o), 64'(32'hAB));
    tick();
    chk("order_en_b", 64'(ALUEn_o), 64'(1));
    chk("order_id_b", 64'(ALUId_o), 64'(5));
    tick();
    chk("order_idle", 64'(ALUEn_o), 64'(0));

    // Flush with waiting entries plus one ready entry about to issue.
    dispatch(0, 0, 32'h70, 32'h71, 7);
    tick(); idle();
    clr_i = 1'b1;
    tick(); idle();
    chk("clr_en", 64'(ALUEn_o), 64'(0));
    chk("clr_id", 64'(ALUId_o), 64'(0));
    chk("clr_r1", 64'(ALUr1Data_o), 64'(0));
    chk("clr_full", 64'(RSFull_o), 64'(0));
    cdb1(9, 32'h99);
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_no_issue", 64'(ALUEn_o), 64'(0));
    end

    // Freeze: no issue, no write, no snoop while rdy=0; outputs hold.
    do_reset();
    dispatch(11, 0, 0, 0, 5);       tick();
    dispatch(0, 0, 32'h21, 0, 2);   tick();
    dispatch(0, 0, 32'h31, 0, 3);   tick();
    chk("frz_pre_en", 64'(ALUEn_o), 64'(1));
    chk("frz_pre_id", 64'(ALUId_o), 64'(2));
    dispatch(0, 0, 32'h41, 0, 4);
    cdb1(11, 32'h99);
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("frz_hold_en", 64'(ALUEn_o), 64'(1));
      chk("frz_hold_id", 64'(ALUId_o), 64'(2));
      chk("frz_hold_r1", 64'(ALUr1Data_o), 64'(32'h21));
    end
    idle();
    tick();
    chk("frz_resume_en", 64'(ALUEn_o), 64'(1));
    chk("frz_resume_id", 64'(ALUId_o), 64'(3));
    tick();
    chk("frz_no_capture", 64'(ALUEn_o), 64'(0));
    cdb1(11, 32'h55);
    tick(); idle();
    tick();
    chk("frz_late_en", 64'(ALUEn_o), 64'(1));
    chk("frz_late_id", 64'(ALUId_o), 64'(5));
    chk("frz_late_r1", 64'(ALUr1Data_o), 64'(32'h55));

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rdy      = ($urandom_range(0, 9) != 0);
      clr_i    = ($urandom_range(0, 149) == 0);
      RSEn_i   = ($urandom_range(0, 2) != 0);
      RSr1Id_i = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      RSr2Id_i = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      RSr1Data_i = $urandom; RSr2Data_i = $urandom;
      RSId_i = 4'($urandom_range(1, 15));
      RSOpcode_i = 6'($urandom); RSPc_i = $urandom; RSImm_i = $urandom;
      cdb1En_i = ($urandom_range(0, 1) == 0); cdb1Id_i = 4'($urandom_range(0, 15)); cdb1Data_i = $urandom;
      cdb2En_i = ($urandom_range(0, 1) == 0); cdb2Id_i = 4'($urandom_range(0, 15)); cdb2Data_i = $urandom;
      tick();
      chk("rnd_full", 64'(RSFull_o), 64'(m_full()));
      chk("rnd_en", 64'(ALUEn_o), 64'(m_en));
      chk("rnd_id", 64'(ALUId_o), 64'(m_id));
      chk("rnd_r1", 64'(ALUr1Data_o), 64'(m_r1));
      chk("rnd_r2", 64'(ALUr2Data_o), 64'(m_r2));
      chk("rnd_op", 64'(ALUOpcode_o), 64'(m_op));
      chk("rnd_pc", 64'(ALUPc_o), 64'(m_pc));
      chk("rnd_imm", 64'(ALUImm_o), 64'(m_imm));
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
